// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the program-counter unit
// Purpose: FSM state encoding and alignment helper used by pc_unit and pc_next_sel.
// Ports: none (package).
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    // Number of low address bits that must be zero for an aligned target.
    function automatic int align_lsb(input int align_bytes);
        return $clog2(align_bytes);
    endfunction

endpackage

// File: rtl/pc_if.sv
// rtl/pc_if.sv - fetch-side and control-side signal bundle for pc_unit
// Purpose: groups the fetch handshake, redirect/trap requests and status outputs.
// Ports (signals):
//   fetch_ready, redirect_valid, redirect_target, trap_valid, trap_vec,
//   halt_req, resume_req                      -> into pc_unit
//   pc, pc_valid, pc_plus_inc, misalign_err,
//   halted                                    <- from pc_unit
// Modports: master = pc_unit side, slave = fetch/branch/trap environment side.
interface pc_if #(
    parameter int XLEN = 32
);
    logic            fetch_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vec;
    logic            halt_req;
    logic            resume_req;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] pc_plus_inc;
    logic            misalign_err;
    logic            halted;

    modport master (
        input  fetch_ready, redirect_valid, redirect_target,
        input  trap_valid, trap_vec, halt_req, resume_req,
        output pc, pc_valid, pc_plus_inc, misalign_err, halted
    );

    modport slave (
        output fetch_ready, redirect_valid, redirect_target,
        output trap_valid, trap_vec, halt_req, resume_req,
        input  pc, pc_valid, pc_plus_inc, misalign_err, halted
    );

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority mux and misalign check
// Purpose: picks the next fetch address (trap > redirect > sequential > hold).
// Ports:
//   state_i            current FSM state (nothing changes while booting)
//   pc_i               current registered pc
//   fire_i             current fetch accepted by instruction memory
//   redirect_valid_i   branch/jump taken
//   redirect_target_i  branch/jump target
//   trap_valid_i       trap entry request
//   trap_vec_i         trap handler base (low alignment bits dropped)
//   next_pc_o          pc for the next cycle
//   misalign_o         the redirect in progress had a misaligned target
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INC_BYTES   = 4,
    parameter int ALIGN_BYTES = 4
) (
    input  pc_state_t       state_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            fire_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);

    localparam int              ALSB       = align_lsb(ALIGN_BYTES);
    // Mask form avoids a zero-width slice when ALIGN_BYTES is 1.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALSB) - 64'd1);
    localparam logic [XLEN-1:0] INC        = XLEN'(INC_BYTES);

    logic            active;
    logic            target_bad;
    logic [XLEN-1:0] trap_base;

    always_comb begin
        active     = (state_i != PC_BOOT);
        trap_base  = trap_vec_i & ~ALIGN_MASK;
        target_bad = (redirect_target_i & ALIGN_MASK) != '0;
        next_pc_o  = pc_i;
        misalign_o = 1'b0;
        if (active) begin
            if (trap_valid_i) begin
                next_pc_o = trap_base;
            end else if (redirect_valid_i) begin
                // A bad target is treated as an exception: go to the handler.
                if (target_bad) begin
                    next_pc_o  = trap_base;
                    misalign_o = 1'b1;
                end else begin
                    next_pc_o = redirect_target_i;
                end
            end else if (fire_i) begin
                next_pc_o = pc_i + INC;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - RV32I fetch-stage program counter with handshake, redirect, trap and halt
// Purpose: holds the fetch PC and BOOT/RUN/HALT state, offers pc to instruction memory.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   pc_if.master: fetch handshake, redirect/trap/halt controls, status outputs
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INC_BYTES   = 4,
    parameter int              ALIGN_BYTES = 4
) (
    input  logic   clk,
    input  logic   rst,
    pc_if.master   bus
);

    localparam logic [XLEN-1:0] INC = XLEN'(INC_BYTES);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            fire;
    logic            misalign_now;

    // A fetch is only ever offered in RUN, so pc_valid is the RUN decode.
    assign fire = (state_q == PC_RUN) & bus.fetch_ready;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INC_BYTES   (INC_BYTES),
        .ALIGN_BYTES (ALIGN_BYTES)
    ) u_next_sel (
        .state_i           (state_q),
        .pc_i              (pc_q),
        .fire_i            (fire),
        .redirect_valid_i  (bus.redirect_valid),
        .redirect_target_i (bus.redirect_target),
        .trap_valid_i      (bus.trap_valid),
        .trap_vec_i        (bus.trap_vec),
        .next_pc_o         (pc_d),
        .misalign_o        (misalign_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        misalign_d = misalign_now;
        case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN: begin
                if (bus.halt_req) begin
                    state_d = PC_HALT;
                end
            end
            PC_HALT: begin
                // Trap entry wins over a pending halt request.
                if (bus.trap_valid || (bus.resume_req && !bus.halt_req)) begin
                    state_d = PC_RUN;
                end
            end
            default: begin
                state_d    = PC_BOOT;
                misalign_d = 1'b0;
            end
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = (state_q == PC_RUN);
    assign bus.halted       = (state_q == PC_HALT);
    assign bus.misalign_err = misalign_q;
    assign bus.pc_plus_inc  = pc_q + INC;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit
module tb_pc_unit;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] INC       = 32'd4;
    localparam logic [31:0] ALIGN     = 32'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_if #(.XLEN(XLEN)) bus ();

    pc_unit #(
        .XLEN        (XLEN),
        .RESET_VEC   (RESET_VEC),
        .INC_BYTES   (4),
        .ALIGN_BYTES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halt;
    bit          m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", bus.pc, m_pc);
        chk("pc_valid", {31'd0, bus.pc_valid}, {31'd0, !m_boot && !m_halt});
        chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
        chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_mis});
        chk("pc_plus_inc", bus.pc_plus_inc, m_pc + INC);
    endtask

    // Applies one cycle of inputs, advances the reference model, then checks.
    task automatic cycle(input bit r, input bit fr, input bit rv, input logic [31:0] rt,
                         input bit tv, input logic [31:0] tvec, input bit hr, input bit rr);
        logic [31:0] tbase;
        tbase               = tvec - (tvec % ALIGN);
        rst                 = r;
        bus.fetch_ready     = fr;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.trap_valid      = tv;
        bus.trap_vec        = tvec;
        bus.halt_req        = hr;
        bus.resume_req      = rr;
        if (r) begin
            m_pc   = RESET_VEC;
            m_boot = 1'b1;
            m_halt = 1'b0;
            m_mis  = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_mis  = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (tv) begin
                m_pc = tbase;
            end else if (rv) begin
                if ((rt % ALIGN) != 0) begin
                    m_pc  = tbase;
                    m_mis = 1'b1;
                end else begin
                    m_pc = rt;
                end
            end else if (!m_halt && fr) begin
                m_pc = m_pc + INC;
            end
            if (m_halt) m_halt = !(tv || (rr && !hr));
            else        m_halt = hr;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset held for two cycles
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_pc_valid", {31'd0, bus.pc_valid}, 32'd0);
        // BOOT -> RUN, first fetch of RESET_VEC offered
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("boot_pc", bus.pc, 32'h0);
        // Stall pattern 1,0,0,1
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_hold", bus.pc, 32'h4);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_end", bus.pc, 32'h8);
        // Redirect while stalled, then misaligned redirect
        cycle(0, 0, 1, 32'h100, 0, 32'h203, 0, 0);
        chk("redir_pc", bus.pc, 32'h100);
        cycle(0, 0, 1, 32'h102, 0, 32'h203, 0, 0);
        chk("misalign_pc", bus.pc, 32'h200);
        chk("misalign_pulse", {31'd0, bus.misalign_err}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("misalign_drop", {31'd0, bus.misalign_err}, 32'd0);
        // Trap beats redirect
        cycle(0, 0, 1, 32'h400, 1, 32'h203, 0, 0);
        chk("trap_pc", bus.pc, 32'h200);
        // Halt while firing, halt+resume, resume
        cycle(0, 0, 1, 32'h10, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 1, 0);
        chk("halt_pc", bus.pc, 32'h14);
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        cycle(0, 1, 0, 0, 0, 0, 1, 1);
        chk("halt_stays", {31'd0, bus.halted}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk("resume_valid", {31'd0, bus.pc_valid}, 32'd1);
        chk("resume_pc", bus.pc, 32'h14);
        // Wrap at top of address space
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", bus.pc, 32'h0);
        // Reset during HALT
        cycle(0, 1, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_halt_flag", {31'd0, bus.halted}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rt;
            logic [31:0] tvec;
            rt   = $urandom;
            tvec = $urandom;
            if ($urandom_range(0, 1) == 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFF8;
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, rt, $urandom_range(0, 15) == 0, tvec,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
